// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing generator: horizontal and
// vertical phase enum, 640x480@60 default timings and the colour-bar table.
package video_timing_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FP     = 2'd1,
      SYNC   = 2'd2,
      BP     = 2'd3
   } phase_e;

   // 640x480@60 with a 25 MHz pixel clock derived from 50 MHz
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_FRAME_W  = 8;

   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0] COLOR_BARS [0:7] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      return COLOR_BARS[idx];
   endfunction

endpackage

// File: rtl/video_timing_gen_pix_ce_gen.sv
// Pixel clock-enable divider: one registered strobe every CLK_DIV clk cycles.
// The strobe is held (not cleared) while enable is low so that the pixel
// step it represents is taken as soon as enable returns; the consumer must
// qualify it with enable.
module pix_ce_gen
   import video_timing_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic pix_ce
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Divider count 0..CLK_DIV-1; strobe follows the terminal count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         pix_ce <= 1'b0;
      end else if (enable) begin
         pix_ce <= (cnt == LAST);
         cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel/line counters, ACTIVE/FP/SYNC/BP phase FSMs,
// registered sync/de/position outputs and a frame counter.
// Optional colour-bar test pattern on output rgb when VIDEO_TIMING_TESTPAT_EN
// is defined; without it the rgb port and its logic are absent.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FRAME_W    = DEF_FRAME_W
) (
   input  logic                                            clk,
   input  logic                                            reset_n,
   input  logic                                            enable,
   output logic                                            pix_ce,
   output logic                                            hsync,
   output logic                                            vsync,
   output logic                                            de,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]    x,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]    y,
   output logic                                            line_start,
   output logic                                            frame_start,
   output logic [FRAME_W-1:0]                              frame_cnt
`ifdef VIDEO_TIMING_TESTPAT_EN
   ,
   output logic [23:0]                                     rgb
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);

   // Last coordinate of each phase
   localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] H_FP_END   = XW'(H_ACTIVE + H_FP - 1);
   localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE - 1);
   localparam logic [YW-1:0] V_FP_END   = YW'(V_ACTIVE + V_FP - 1);
   localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

   localparam logic HS_ON  = (H_SYNC_POL != 0);
   localparam logic HS_OFF = !HS_ON;
   localparam logic VS_ON  = (V_SYNC_POL != 0);
   localparam logic VS_OFF = !VS_ON;

   if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
       V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
       CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_param
      $error("video_timing_gen: zero timing parameter or CLK_DIV outside 1..16");
   end

   logic               ce_raw;
   logic               adv;
   logic               h_wrap;
   logic               f_wrap;
   logic [XW-1:0]      cx;
   logic [YW-1:0]      cy;
   logic [FRAME_W-1:0] fcnt;
   phase_e             h_state, h_state_nxt;
   phase_e             v_state, v_state_nxt;
   logic               px_active;
   logic               h_sync_on;
   logic               v_sync_on;

   pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_pix_ce_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .pix_ce  (ce_raw)
   );

   // cx/cy name the pixel that the next step presents on the outputs
   assign adv    = ce_raw & enable;
   assign h_wrap = adv && (cx == H_LAST);
   assign f_wrap = h_wrap && (cy == V_LAST);

   // Position counters and frames-completed count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx   <= '0;
         cy   <= '0;
         fcnt <= '0;
      end else if (adv) begin
         cx <= h_wrap ? '0 : cx + XW'(1);
         if (h_wrap)
            cy <= (cy == V_LAST) ? '0 : cy + YW'(1);
         if (f_wrap)
            fcnt <= fcnt + FRAME_W'(1);
      end
   end

   // Phase state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_state <= ACTIVE;
         v_state <= ACTIVE;
      end else begin
         h_state <= h_state_nxt;
         v_state <= v_state_nxt;
      end
   end

   // Phase transitions: horizontal on the step leaving a boundary pixel,
   // vertical only on the step that wraps the line
   always_comb begin
      h_state_nxt = h_state;
      if (adv) begin
         case (h_state)
            ACTIVE:  if (cx == H_ACT_END)  h_state_nxt = FP;
            FP:      if (cx == H_FP_END)   h_state_nxt = SYNC;
            SYNC:    if (cx == H_SYNC_END) h_state_nxt = BP;
            BP:      if (cx == H_LAST)     h_state_nxt = ACTIVE;
            default:                       h_state_nxt = ACTIVE;
         endcase
      end
      v_state_nxt = v_state;
      if (h_wrap) begin
         case (v_state)
            ACTIVE:  if (cy == V_ACT_END)  v_state_nxt = FP;
            FP:      if (cy == V_FP_END)   v_state_nxt = SYNC;
            SYNC:    if (cy == V_SYNC_END) v_state_nxt = BP;
            BP:      if (cy == V_LAST)     v_state_nxt = ACTIVE;
            default:                       v_state_nxt = ACTIVE;
         endcase
      end
   end

   // Phase decode for the pixel about to be presented
   always_comb begin
      px_active = (h_state == ACTIVE) && (v_state == ACTIVE);
      h_sync_on = (h_state == SYNC);
      v_sync_on = (v_state == SYNC);
   end

   // Registered outputs; everything except the strobes holds between steps
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_ce      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         hsync       <= HS_OFF;
         vsync       <= VS_OFF;
         frame_cnt   <= '0;
      end else begin
         pix_ce      <= adv;
         line_start  <= adv && (cx == '0);
         frame_start <= adv && (cx == '0) && (cy == '0);
         if (adv) begin
            x         <= cx;
            y         <= cy;
            de        <= px_active;
            hsync     <= h_sync_on ? HS_ON : HS_OFF;
            vsync     <= v_sync_on ? VS_ON : VS_OFF;
            frame_cnt <= fcnt;
         end
      end
   end

`ifdef VIDEO_TIMING_TESTPAT_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [2:0] rot;
   logic [2:0] bar_idx;
   int         bar_raw;

   // Bar under the current pixel; any remainder columns extend the last bar
   always_comb begin
      bar_raw = int'(cx) / BAR_W;
      bar_idx = (bar_raw > 7) ? 3'd7 : 3'(bar_raw);
   end

   // Bar rotation advances once per frame, visible from the next frame_start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rot <= '0;
         rgb <= '0;
      end else if (adv) begin
         if (f_wrap)
            rot <= rot + 3'd1;
         rgb <= px_active ? bar_color(bar_idx + rot) : 24'h000000;
      end
   end
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, the vertical equivalents in lines.
REQ-006 The block SHALL have parameter H_SYNC_POL and V_SYNC_POL, default 0, where 0 means the sync pulse is active-low.
REQ-007 The block SHALL have parameter CLK_DIV, default 2, the number of clk cycles per pixel (1..16).
REQ-008 The block SHALL have parameter FRAME_W, default 8, the frame counter width.
REQ-009 clk  in  1  the system clock (50 MHz on the board); the block uses this one clock only.
REQ-010 reset_n  in  1  the reset; it is asynchronous and active-low.
REQ-011 enable  in  1  the run control; while it is low the counters hold.
REQ-012 pix_ce  out  1  the pixel clock enable, high for one clk in every CLK_DIV.
REQ-013 hsync, vsync  out  1 each  the sync pulses, with polarity set by the parameters.
REQ-014 de  out  1  high while the current pixel is inside the active window.
REQ-015 x, y  out  $clog2(H_TOTAL), $clog2(V_TOTAL)  the current pixel and line position.
REQ-016 line_start, frame_start  out  1 each  one-clk pulses that fire on the pix_ce where x==0, or where x==0 and y==0.
REQ-017 frame_cnt  out  FRAME_W  the count of frames completed.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be defined in the same way.
REQ-019 Pixel enable: a divider counter SHALL count 0..CLK_DIV-1, and pix_ce SHALL assert when the counter is at CLK_DIV-1; when CLK_DIV==1, pix_ce SHALL be constantly high outside reset.
REQ-020 x SHALL advance by 1 on each pix_ce and wrap H_TOTAL-1 -> 0; y SHALL advance only on the pix_ce where x wraps, and y SHALL wrap V_TOTAL-1 -> 0.
REQ-021 The active region SHALL be x<H_ACTIVE and y<V_ACTIVE, and de SHALL be high exactly there.
REQ-022 Horizontal phases SHALL run in the order ACTIVE -> FP -> SYNC -> BP (FSM state vector h_state), and vertical phases SHALL run in the same order (v_state); h_state SHALL change on the pix_ce where x crosses a boundary.
REQ-023 hsync SHALL be active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and vsync SHALL be active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; the vertical phase SHALL update only at a line wrap.
REQ-024 All outputs SHALL be registered, with a latency of 1 clk from the counter update to the output.
REQ-025 frame_cnt SHALL increment when y wraps V_TOTAL-1 -> 0, wrap modulo 2^FRAME_W, and be clocked by clk; no logic SHALL be clocked by sync signals.
REQ-026 When enable is low, the divider, x, y and frame_cnt SHALL freeze, pix_ce, line_start and frame_start SHALL be 0, and sync and de SHALL hold their values; when enable rises, counting SHALL resume from the frozen point.
REQ-027 Elaboration SHALL fail if any porch, sync or active parameter is 0, or if CLK_DIV is outside 1..16.

Reset
REQ-028 Asserting reset_n low SHALL immediately set: the divider, x, y and frame_cnt to 0; pix_ce, de, line_start and frame_start to 0; and hsync and vsync to their inactive level.
REQ-029 After reset_n deasserts, the first pix_ce SHALL start pixel (0,0) and assert frame_start.
REQ-030 A reset in mid-frame SHALL abandon the frame without incrementing frame_cnt.

Configuration
REQ-031 When macro VIDEO_TIMING_TESTPAT_EN is defined, the block SHALL add output rgb (24 bits): 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), forced to 0 when de is low, with the bar order rotating by one on each frame_start.
REQ-032 When VIDEO_TIMING_TESTPAT_EN is undefined, the rgb port and its logic SHALL be absent.

Structure
REQ-033 Package video_timing_pkg SHALL hold: the phase enum (ACTIVE, FP, SYNC, BP), the 640x480@60 default constants, and the colour-bar constant table.
REQ-034 The divider SHALL be one sub-module, pix_ce_gen (parameter CLK_DIV; ports clk, reset_n, enable, pix_ce).

Verification
REQ-035 With defaults, running for 2 frames SHALL give hsync low for exactly 96 pixels starting at x=656, vsync low for lines 490..491, 800 pix_ce per line, and 420000 per frame.
REQ-036 With CLK_DIV=1 and small timings of 8/2/2/2 horizontal and 4/1/1/1 vertical, H_TOTAL SHALL be 14, V_TOTAL SHALL be 7, and de SHALL be high for 32 pix_ce per frame.
REQ-037 With enable low for 37 clks at x=100 and y=5, the outputs SHALL hold and counting SHALL resume at x=101 on the next pix_ce.
REQ-038 With reset_n asserted at x=400 and y=300, the outputs SHALL be zero or inactive in the same cycle, frame_cnt SHALL stay unchanged, and frame_start SHALL fire on the first pix_ce after release.
REQ-039 With FRAME_W=2, after 5 frames frame_cnt SHALL read 1, having wrapped from 3 to 0.
REQ-040 With VIDEO_TIMING_TESTPAT_EN defined, x=0 in frame 0 SHALL give rgb=FFFFFF, x=80 SHALL give FFFF00, and frame 1 at x=0 SHALL give FFFF00.
